// File: rtl/clock_disp_pkg.sv
// Shared constants for the clock display scanner: digit positions, segment codes, legal maxima
// and a binary-to-BCD split helper.
package clock_disp_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  // Logical (active-high) segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  localparam logic [2:0] DIG_SEC_U = 3'd0;
  localparam logic [2:0] DIG_SEC_T = 3'd1;
  localparam logic [2:0] DIG_MIN_U = 3'd2;
  localparam logic [2:0] DIG_MIN_T = 3'd3;
  localparam logic [2:0] DIG_HR_U  = 3'd4;
  localparam logic [2:0] DIG_HR_T  = 3'd5;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [4:0] HR_MAX  = 5'd23;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_pair_t;

  // Any 6-bit value splits into tens 0..6 and units 0..9, so 4 bits each suffice.
  function automatic bcd_pair_t to_bcd(input logic [5:0] v);
    bcd_pair_t r;
    r.tens  = 4'(v / 6'd10);
    r.units = 4'(v % 6'd10);
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-to-7-segment decoder producing logical (active-high) segments;
// the dash flag overrides the digit value.
module seg7_decode
  import clock_disp_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    if (dash) begin
      seg = SEG_DASH;
    end else begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = 7'h00;
      endcase
    end
  end

endmodule

// File: rtl/clock_display_scan.sv
// Scans a 6-digit HH:MM:SS 7-segment display from a per-frame snapshot of sec/min/hr.
// Optional colon blink on the decimal points is enabled by defining CLOCK_DISPLAY_DP_BLINK_EN.
module clock_display_scan
  import clock_disp_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned SCAN_HZ        = 1_000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            sec,
  input  logic [5:0]            min,
  input  logic [4:0]            hr,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int unsigned DIV      = CLK_HZ / (SCAN_HZ * NUM_DIGITS);
  localparam int unsigned DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic        INV      = SEG_ACTIVE_LOW;

  if (DIV < 1) begin : g_div_check
    $error("clock_display_scan: CLK_HZ/(SCAN_HZ*6) must be at least 1");
  end

  logic [DIV_W-1:0] div_cnt_q;
  logic [2:0]       dig_idx_q;
  logic [5:0]       snap_sec_q;
  logic [5:0]       snap_min_q;
  logic [4:0]       snap_hr_q;
  logic             load_pending_q;

  logic             step;
  logic             snap_load;
  bcd_pair_t        sec_bcd;
  bcd_pair_t        min_bcd;
  bcd_pair_t        hr_bcd;
  logic             sec_bad;
  logic             min_bad;
  logic             hr_bad;
  logic [3:0]       digit_bcd;
  logic             digit_dash;
  logic [6:0]       seg_log;
  logic [NUM_DIGITS-1:0] an_log;
  logic             dp_log;

  assign step = (div_cnt_q == DIV_LAST);
  // Snapshot only at frame boundaries so a frame never mixes two times.
  assign snap_load = load_pending_q | (step & (dig_idx_q == DIG_HR_T));

  assign sec_bcd = to_bcd(snap_sec_q);
  assign min_bcd = to_bcd(snap_min_q);
  assign hr_bcd  = to_bcd({1'b0, snap_hr_q});
  assign sec_bad = (snap_sec_q > SEC_MAX);
  assign min_bad = (snap_min_q > MIN_MAX);
  assign hr_bad  = (snap_hr_q > HR_MAX);

  always_comb begin
    digit_bcd  = 4'd0;
    digit_dash = 1'b0;
    case (dig_idx_q)
      DIG_SEC_U: begin digit_bcd = sec_bcd.units; digit_dash = sec_bad; end
      DIG_SEC_T: begin digit_bcd = sec_bcd.tens;  digit_dash = sec_bad; end
      DIG_MIN_U: begin digit_bcd = min_bcd.units; digit_dash = min_bad; end
      DIG_MIN_T: begin digit_bcd = min_bcd.tens;  digit_dash = min_bad; end
      DIG_HR_U:  begin digit_bcd = hr_bcd.units;  digit_dash = hr_bad;  end
      DIG_HR_T:  begin digit_bcd = hr_bcd.tens;   digit_dash = hr_bad;  end
      default:   ;
    endcase
  end

  seg7_decode u_seg7_decode (
    .bcd  (digit_bcd),
    .dash (digit_dash),
    .seg  (seg_log)
  );

  assign an_log = NUM_DIGITS'(1) << dig_idx_q;

`ifdef CLOCK_DISPLAY_DP_BLINK_EN
  // Colon dots sit on the minute-units and hour-units digits; lit on even seconds.
  assign dp_log = ((dig_idx_q == DIG_MIN_U) || (dig_idx_q == DIG_HR_U)) && !snap_sec_q[0];
`else
  assign dp_log = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q      <= '0;
      dig_idx_q      <= DIG_SEC_U;
      snap_sec_q     <= '0;
      snap_min_q     <= '0;
      snap_hr_q      <= '0;
      load_pending_q <= 1'b1;
      an             <= {NUM_DIGITS{INV}};
      seg            <= {7{INV}};
      dp             <= INV;
    end else begin
      div_cnt_q <= step ? '0 : div_cnt_q + 1'b1;
      if (step) begin
        dig_idx_q <= (dig_idx_q == DIG_HR_T) ? DIG_SEC_U : dig_idx_q + 3'd1;
      end
      if (snap_load) begin
        snap_sec_q <= sec;
        snap_min_q <= min;
        snap_hr_q  <= hr;
      end
      load_pending_q <= 1'b0;
      an             <= an_log ^ {NUM_DIGITS{INV}};
      seg            <= seg_log ^ {7{INV}};
      dp             <= dp_log ^ INV;
    end
  end

endmodule
